spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on each of nCS, SCLK and COPI; legal range 2..4.
REQ-002 Parameter MAX_ADDR, default 4: highest implemented register address.
REQ-003 clk  input  1  system clock; all state on its rising edge; SCLK frequency SHALL be at most clk/8.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 nCS  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SCLK  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
REQ-007 COPI  input  1  controller-out serial data, MSB first.
REQ-008 CIPO  output  1  peripheral-out serial data for reads, MSB first.
REQ-009 en_reg_out_7_0  output  8  register 0x00: output enables, bits 7:0.
REQ-010 en_reg_out_15_8  output  8  register 0x01: output enables, bits 15:8.
REQ-011 en_reg_pwm_7_0  output  8  register 0x02: PWM enables, bits 7:0.
REQ-012 en_reg_pwm_15_8  output  8  register 0x03: PWM enables, bits 15:8.
REQ-013 pwm_duty_cycle  output  8  register 0x04: shared PWM duty cycle.

Function
REQ-014 nCS, SCLK and COPI SHALL each pass through SYNC_STAGES flops before any use; edges SHALL be detected from the last two synchronized stages.
REQ-015 Frame = 16 bits: bit 15 R/W (1 = write, 0 = read), bits 14:8 address, bits 7:0 data.
REQ-016 States: IDLE (nCS high), SHIFT (nCS low), COMMIT (one cycle after synchronized nCS rise), then IDLE.
REQ-017 Synchronized nCS fall SHALL clear the 5-bit bit counter and the shift register and enter SHIFT.
REQ-018 In SHIFT, each synchronized SCLK rise SHALL shift synchronized COPI into the shift register LSB; the counter increments and saturates at 17.
REQ-019 SCLK edges while synchronized nCS is high SHALL be ignored.
REQ-020 A write SHALL commit in COMMIT only if counter == 16, R/W == 1 and address <= MAX_ADDR; the addressed register takes bits 7:0 and no other register changes.
REQ-021 Counter != 16, address > MAX_ADDR, or R/W == 0 SHALL leave all registers unchanged.
REQ-022 Commit latency: the register SHALL update within SYNC_STAGES+2 clk cycles of the nCS pin rising.
REQ-023 Read: when counter reaches 8 with R/W == 0, the addressed register value SHALL load into an 8-bit output shifter; an invalid address SHALL load 0x00.
REQ-024 Read data: the output-shifter MSB SHALL drive CIPO from the first synchronized SCLK fall after bit 8; the shifter shifts left on each subsequent synchronized SCLK fall, 8 bits total.
REQ-025 CIPO SHALL be 0 outside a read data phase, after bit 16, and whenever synchronized nCS is high.
REQ-026 nCS rising mid-frame SHALL abort the frame per REQ-021; the next nCS fall restarts cleanly.
REQ-027 A new nCS fall arriving before COMMIT completes SHALL still commit the prior frame first; the new frame's counter starts at 0.

Reset
REQ-028 rst_n low SHALL immediately clear all five registers to 0x00, CIPO to 0, the counter, shift register and output shifter to 0, the state to IDLE, and all synchronizer flops to nCS=1, SCLK=0, COPI=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, the first valid frame SHALL behave normally.

Verification
REQ-030 Write 0x80_FF (reg 0x00 = 0xFF) -> en_reg_out_7_0 = 0xFF within SYNC_STAGES+2 cycles of nCS rise; other registers stay 0x00.
REQ-031 Writes 0x84_80, then 0x83_A5 -> pwm_duty_cycle = 0x80, en_reg_pwm_15_8 = 0xA5; register 0x02 stays 0x00.
REQ-032 Write 0x85_12 (address 5), then a 12-bit frame 0x81F, then a 17-bit frame -> all registers unchanged.
REQ-033 After writing 0x82_3C, read 0x02_00 -> CIPO returns 0x3C over the last 8 SCLK rises; read of address 0x7F returns 0x00.
REQ-034 rst_n pulsed low after 10 of 16 SCLK edges of a write to 0x04 -> all outputs 0x00; next write 0x84_55 -> pwm_duty_cycle = 0x55.
REQ-035 SCLK toggled 20 times with nCS high, then a write 0x81_0F -> only en_reg_out_15_8 = 0x0F.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral with five 8-bit control registers.
// Frame: bit 15 R/W (1 = write), bits 14:8 address, bits 7:0 data, MSB first.
// All SPI pins are asynchronous to clk and pass through SYNC_STAGES flops (2..4).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | nCS high, waiting for a synchronized nCS fall
// ST_SHIFT  | nCS low, shifting COPI on SCLK rise, driving CIPO on fall
// ST_COMMIT | one cycle after nCS rise, a complete valid write lands here
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nCS,
  input  logic       SCLK,
  input  logic       COPI,
  output logic       CIPO,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  // Only five registers physically exist, so clamp the decode range.
  localparam int         LP_LAST_INT = (MAX_ADDR < 4) ? MAX_ADDR : 4;
  localparam logic [6:0] LP_LAST     = 7'(LP_LAST_INT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;

  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_out;
  logic [3:0]  r_rd_cnt;
  logic        r_rd_act;
  logic        r_cipo;

  logic [7:0] r_reg0;
  logic [7:0] r_reg1;
  logic [7:0] r_reg2;
  logic [7:0] r_reg3;
  logic [7:0] r_reg4;

  logic        w_ncs_lvl;
  logic        w_ncs_fall;
  logic        w_ncs_rise;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_copi;
  logic [15:0] w_shift_nxt;
  logic [6:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic        w_start;
  logic        w_shift_en;
  logic        w_fall_en;
  logic        w_commit_ok;

  // Synchronizer chains; reset to the idle bus levels so no false edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_sync  <= '1;
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
    end
  end

  assign w_ncs_lvl   = r_ncs_sync[SYNC_STAGES-1];
  assign w_ncs_fall  =  r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_sync[SYNC_STAGES-2];
  assign w_ncs_rise  = ~r_ncs_sync[SYNC_STAGES-1] &  r_ncs_sync[SYNC_STAGES-2];
  assign w_sclk_rise = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_sync[SYNC_STAGES-2];
  assign w_sclk_fall =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES-2];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes. A fall seen during COMMIT
  // goes straight back to SHIFT so the pending write is not lost.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_fall_en   = 1'b0;
    w_commit_ok = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift_en = w_sclk_rise;
        w_fall_en  = w_sclk_fall;
        if (w_ncs_rise) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit_ok = (r_cnt == 5'd16) && r_shift[15] && (r_shift[14:8] <= LP_LAST);
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_shift_nxt = {r_shift[14:0], w_copi};
  assign w_rd_addr   = w_shift_nxt[6:0];

  // Read-back mux, addressed by the header byte as it completes.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr <= LP_LAST) begin
      case (w_rd_addr)
        7'd0:    w_rd_data = r_reg0;
        7'd1:    w_rd_data = r_reg1;
        7'd2:    w_rd_data = r_reg2;
        7'd3:    w_rd_data = r_reg3;
        7'd4:    w_rd_data = r_reg4;
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  // Input shifter, bit counter and read output shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_out    <= '0;
      r_rd_cnt <= '0;
      r_rd_act <= 1'b0;
      r_cipo   <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_out    <= '0;
      r_rd_cnt <= '0;
      r_rd_act <= 1'b0;
      r_cipo   <= 1'b0;
    end else if (r_state != ST_SHIFT) begin
      r_rd_act <= 1'b0;
      r_cipo   <= 1'b0;
    end else if (w_shift_en) begin
      r_shift <= w_shift_nxt;
      if (r_cnt != 5'd17) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if ((r_cnt == 5'd7) && !w_shift_nxt[7]) begin
        r_out    <= w_rd_data;
        r_rd_act <= 1'b1;
        r_rd_cnt <= '0;
      end
      if (r_cnt >= 5'd16) begin
        r_rd_act <= 1'b0;
        r_cipo   <= 1'b0;
      end
    end else if (w_fall_en && r_rd_act) begin
      if (r_rd_cnt == 4'd8) begin
        r_rd_act <= 1'b0;
        r_cipo   <= 1'b0;
      end else begin
        r_cipo   <= r_out[7];
        r_out    <= {r_out[6:0], 1'b0};
        r_rd_cnt <= r_rd_cnt + 4'd1;
      end
    end
  end

  // Register file; only the addressed register takes the data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg0 <= '0;
      r_reg1 <= '0;
      r_reg2 <= '0;
      r_reg3 <= '0;
      r_reg4 <= '0;
    end else if (w_commit_ok) begin
      case (r_shift[14:8])
        7'd0:    r_reg0 <= r_shift[7:0];
        7'd1:    r_reg1 <= r_shift[7:0];
        7'd2:    r_reg2 <= r_shift[7:0];
        7'd3:    r_reg3 <= r_shift[7:0];
        7'd4:    r_reg4 <= r_shift[7:0];
        default: ;
      endcase
    end
  end

  // Gate with synchronized nCS so CIPO drops as soon as the frame ends.
  assign CIPO            = r_cipo & ~w_ncs_lvl;
  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: scoreboard queues of expected register
// snapshots and read bytes, one task per scenario.
module tb_spi_peripheral;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nCS;
  logic       SCLK;
  logic       COPI;
  logic       CIPO;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_reg_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  rd_byte;
  logic        cipo_stray;
  logic [39:0] obs;
  logic [39:0] expv;
  logic [7:0]  exp_b;
  string       reg_name[5] = '{"reg00_out_7_0", "reg01_out_15_8", "reg02_pwm_7_0",
                               "reg03_pwm_15_8", "reg04_duty"};

  spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .nCS             (nCS),
    .SCLK            (SCLK),
    .COPI            (COPI),
    .CIPO            (CIPO),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  assign obs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one frame of n bits (MSB first), SCLK at clk/8, and captures CIPO
  // just before rises 9..16. Returns right after raising nCS.
  task automatic spi_frame(input logic [31:0] bits, input int n);
    rd_byte    = 8'h00;
    cipo_stray = 1'b0;
    @(negedge clk);
    nCS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      COPI = bits[n-1-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) rd_byte = {rd_byte[6:0], CIPO};
      else if (CIPO !== 1'b0) cipo_stray = 1'b1;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (CIPO !== 1'b0) cipo_stray = 1'b1;
    nCS  = 1'b1;
    COPI = 1'b0;
  endtask

  task automatic wait_commit();
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nCS   = 1'b1;
    SCLK  = 1'b0;
    COPI  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_%s: got %h expected 00", reg_name[k], obs[k*8 +: 8]);
      end
    end
    n_checks++;
    if (CIPO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cipo: got %b expected 0", CIPO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_basic();
    exp_reg_q.push_back(40'h00_00_00_00_FF);
    spi_frame(32'h80FF, 16);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL write_basic_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_multi();
    spi_frame(32'h8480, 16);
    repeat (6) @(negedge clk);
    exp_reg_q.push_back(40'h80_A5_00_00_FF);
    spi_frame(32'h83A5, 16);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL write_multi_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_invalid();
    exp_reg_q.push_back(40'h80_A5_00_00_FF);
    spi_frame(32'h8512, 16);
    repeat (6) @(negedge clk);
    spi_frame(32'h081F, 12);
    repeat (6) @(negedge clk);
    spi_frame(32'h180AA, 17);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL invalid_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_read();
    spi_frame(32'h823C, 16);
    repeat (6) @(negedge clk);
    exp_rd_q.push_back(8'h3C);
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'hFF);
    spi_frame(32'h0200, 16);
    exp_b = exp_rd_q.pop_front();
    n_checks++;
    if (rd_byte !== exp_b) begin
      n_fail++;
      $display("FAIL read_reg02: got %h expected %h", rd_byte, exp_b);
    end
    n_checks++;
    if (cipo_stray !== 1'b0) begin
      n_fail++;
      $display("FAIL read_cipo_idle: got stray CIPO=%b expected 0", cipo_stray);
    end
    repeat (6) @(negedge clk);
    spi_frame(32'h7F00, 16);
    exp_b = exp_rd_q.pop_front();
    n_checks++;
    if (rd_byte !== exp_b) begin
      n_fail++;
      $display("FAIL read_reg7f: got %h expected %h", rd_byte, exp_b);
    end
    repeat (6) @(negedge clk);
    spi_frame(32'h0000, 16);
    exp_b = exp_rd_q.pop_front();
    n_checks++;
    if (rd_byte !== exp_b) begin
      n_fail++;
      $display("FAIL read_reg00: got %h expected %h", rd_byte, exp_b);
    end
    n_checks++;
    if (cipo_stray !== 1'b0) begin
      n_fail++;
      $display("FAIL read_cipo_tail: got stray CIPO=%b expected 0", cipo_stray);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (CIPO !== 1'b0) begin
      n_fail++;
      $display("FAIL read_cipo_ncs_high: got %b expected 0", CIPO);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] partial;
    partial = 16'h84AA;
    @(negedge clk);
    nCS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      COPI = partial[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== 8'h00) begin
        n_fail++;
        $display("FAIL midreset_%s: got %h expected 00", reg_name[k], obs[k*8 +: 8]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nCS   = 1'b1;
    COPI  = 1'b0;
    repeat (8) @(negedge clk);
    exp_reg_q.push_back(40'h55_00_00_00_00);
    spi_frame(32'h8455, 16);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL after_reset_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sclk_ignored();
    for (int i = 0; i < 20; i++) begin
      COPI = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    COPI = 1'b0;
    repeat (4) @(negedge clk);
    exp_reg_q.push_back(40'h55_00_00_0F_00);
    spi_frame(32'h810F, 16);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL sclk_ignored_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  // Second frame starts one clk after the first ends, so its nCS fall is
  // seen while the first frame is still committing.
  task automatic test_back_to_back();
    exp_reg_q.push_back(40'h22_00_11_0F_00);
    spi_frame(32'h8211, 16);
    spi_frame(32'h8422, 16);
    wait_commit();
    expv = exp_reg_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs[k*8 +: 8] !== expv[k*8 +: 8]) begin
        n_fail++;
        $display("FAIL back_to_back_%s: got %h expected %h", reg_name[k], obs[k*8 +: 8], expv[k*8 +: 8]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_multi();
    test_invalid();
    test_read();
    test_reset_midframe();
    test_sclk_ignored();
    test_back_to_back();
    n_checks++;
    if (exp_reg_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
               exp_reg_q.size(), exp_rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
